// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the L1 miss fill engine: FSM states, block geometry
// and the nominal memory4c latency assumed by benches.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W       = OFF_W + 1;
    localparam int unsigned MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TAG   = 2'd2
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// Wrapping word-offset counter with a block-complete flag; one copy tracks
// issued reads, another tracks returned words.
module fill_word_counter #(
    parameter  int unsigned WORDS = cache_pkg::BLOCK_WORDS,
    localparam int unsigned OW    = $clog2(WORDS),
    localparam int unsigned CW    = OW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [OW-1:0] start_off,
    input  logic          en,
    output logic [OW-1:0] off,
    output logic          done
);

    logic [OW-1:0] off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The offset wraps on its own; the wider count saturates at WORDS.
    assign done = (cnt_q == CW'(WORDS));
    assign off  = off_q;

    always_comb begin
        off_d = off_q;
        cnt_d = cnt_q;
        if (load) begin
            off_d = start_off;
            cnt_d = '0;
        end else if (en && !done) begin
            off_d = off_q + OW'(1);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q <= '0;
            cnt_q <= '0;
        end else begin
            off_q <= off_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams a block of reads to memory4c, steers returned
// words into the data array, then pulses the tag write. Critical-word-first
// ordering is enabled by defining CACHE_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
    parameter  int unsigned BLOCK_WORDS = 8,
    parameter  int unsigned ADDR_W      = 16,
    localparam int unsigned OW          = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [OW-1:0]     fill_word,
    output logic              write_tag_array
);

    import cache_pkg::*;

    localparam int unsigned BW = ADDR_W - OW - 1;

    fill_state_e   state_q, state_d;
    logic [BW-1:0] base_q, base_d;
    logic [OW-1:0] start_q, start_d;
    logic [OW-1:0] miss_off;
    logic [OW-1:0] issue_off, recv_off;
    logic          issue_done, recv_done;
    logic          load;
    logic          unused_addr_bits;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign miss_off         = miss_address[OW:1];
    assign unused_addr_bits = miss_address[0];
`else
    assign miss_off         = '0;
    assign unused_addr_bits = ^miss_address[OW:0];
`endif

    fill_word_counter #(.WORDS(BLOCK_WORDS)) u_issue_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .start_off (miss_off),
        .en        (memory_enable),
        .off       (issue_off),
        .done      (issue_done)
    );

    fill_word_counter #(.WORDS(BLOCK_WORDS)) u_recv_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .start_off (miss_off),
        .en        (write_data_array),
        .off       (recv_off),
        .done      (recv_done)
    );

    assign fsm_busy = (state_q != IDLE);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        start_d          = start_q;
        load             = 1'b0;
        memory_enable    = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word        = '0;
        write_tag_array  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    load    = 1'b1;
                    base_d  = miss_address[ADDR_W-1:OW+1];
                    start_d = miss_off;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!issue_done) begin
                    memory_enable  = 1'b1;
                    memory_address = {base_q, issue_off, 1'b0};
                end
                if (memory_data_valid && !recv_done) begin
                    write_data_array = 1'b1;
                    fill_word        = recv_off;
                    // Offsets are unique within a fill, so start-1 marks the last word.
                    if (recv_off == start_q - OW'(1)) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                write_tag_array = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            start_q <= start_d;
        end
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling fill engine between the L1 cache controller and the multi-cycle `memory4c` main memory. On a cache miss it latches the miss address and streams read requests for the eight 16-bit words of the 16-byte block. It steers each returned word into the cache data array, then writes the tag/valid metadata once. It holds the cache stalled (`fsm_busy`) for the whole fill.

## Interface
- `BLOCK_WORDS`, 8: words per cache block; power of two; offset width is log2(BLOCK_WORDS).
- `ADDR_W`, 16: byte-address width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `miss_detected`  in  1  cache reports a miss; sampled only in IDLE.
- `miss_address`  in  ADDR_W  byte address of the missing access.
- `memory_data_valid`  in  1  `memory4c` returns one word this cycle.
- `fsm_busy`  out  1  fill in progress; cache must stall.
- `memory_enable`  out  1  issue a read to `memory4c` this cycle.
- `memory_address`  out  ADDR_W  word-aligned read address (bit 0 = 0).
- `write_data_array`  out  1  write the current `memory_data` into the data array.
- `fill_word`  out  3  word offset within the block for the current `write_data_array`.
- `write_tag_array`  out  1  one-cycle pulse to write tag and set valid.

## Operation
- States: IDLE, FETCH, TAG.
- **IDLE:**
  - `miss_detected`=1 latches `miss_address[15:4]` as the block base and the requested word offset `miss_address[3:1]`.
  - Clears `issue_cnt` and `recv_cnt`, then moves to FETCH.
- **FETCH, issue side:**
  - While `issue_cnt` < 8, assert `memory_enable` with `memory_address` = {base, issue_offset, 1'b0}.
  - Increment `issue_cnt` by one per cycle, so there are 8 back-to-back requests.
  - Request order is offsets 0..7.
- **FETCH, receive side:**
  - Each cycle with `memory_data_valid`=1: assert `write_data_array` in the same cycle, drive `fill_word` = recv_offset, and increment `recv_cnt`.
  - Word data itself passes from memory to the data array outside this block.
- When the 8th word is received, move to TAG.
- **TAG:** assert `write_tag_array` for exactly one cycle, then return to IDLE.
- `fsm_busy` = (state != IDLE).
- Offset counters are 3-bit and wrap 7→0. Full/empty is tracked by the 4-bit `issue_cnt`/`recv_cnt`, which range 0..8.
- **Boundary rules:**
  - `miss_detected` in FETCH or TAG: ignored (no queueing).
  - `memory_data_valid` in IDLE or TAG, or after 8 words have been received: ignored, no write.
  - Issue and receive in the same cycle are both processed.
  - `rst` mid-fill: returns to IDLE immediately and zeroes counters and all outputs. `memory4c` shares `rst`, so no stale returns survive reset.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Miss sampled at edge 0:
  - `fsm_busy`=1 and the first `memory_enable` appear in cycle 1.
  - Issues occupy cycles 1–8.
- With the 4-cycle `memory4c` latency:
  - Data arrives in cycles 5–12.
  - `write_tag_array` is asserted in cycle 13.
  - `fsm_busy` falls in cycle 14.
- Fill latency is 13 cycles of stall for a fixed-latency memory. The block is correct for any latency ≥1, because it counts `memory_data_valid` rather than cycles.
- Outputs are Moore/registered except `write_data_array` and `fill_word`, which are combinational from `memory_data_valid` and the registered receive offset.

## Configuration
- `CACHE_CRITICAL_WORD_FIRST_EN` defined:
  - Both issue and receive offsets start at the requested word and wrap modulo 8, e.g. request offset 5 issues 5,6,7,0,1,2,3,4.
  - `fill_word` follows the same order.
- Undefined: both orders start at offset 0.
- Timing is identical in both cases.

## Structure
- Shared package `cache_pkg`: state enum (IDLE/FETCH/TAG), `BLOCK_WORDS`, offset width, `MEM_LATENCY`=4 constant for benches.
- Sub-module `fill_word_counter`: 3-bit wrapping offset counter with load (start offset), enable, and a 4-bit count-done flag. It is instantiated twice, once for issue and once for receive.

## Test plan
- Miss at 0x1236, 4-cycle memory, macro off:
  - Addresses 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - `fill_word` 0..7 in cycles 5–12.
  - Tag pulse in cycle 13; busy low in cycle 14.
- Same miss with `CACHE_CRITICAL_WORD_FIRST_EN`:
  - Addresses 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234.
  - `fill_word` 3,4,5,6,7,0,1,2.
- Second `miss_detected` pulse in cycle 6 → ignored; exactly 8 issues and one tag pulse.
- `rst` asserted in cycle 7 → all outputs 0 that cycle. A new miss at 0xFFF0 after release does a full fill at 0xFFF0–0xFFFE with no address overflow.
- Spurious `memory_data_valid` in IDLE and in TAG → no `write_data_array`, and state is unchanged.
- Stall memory by delaying valids (gaps of 2 cycles) → 8 writes in order; tag only after the 8th.
